// File: rtl/onehot_decoder_pipe.sv
// onehot_decoder_pipe
//   Pipelined binary-to-one-hot / thermometer decoder with valid/ready on
//   both sides, a one-entry skid register behind the output register, and
//   out-of-range detection with a saturating error counter.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_sel is valid
//   in_ready   out  block accepts in_sel this cycle (registered)
//   in_sel     in   SEL_W-bit binary select code
//   out_valid  out  out_dec / out_err are valid
//   out_ready  in   consumer takes the output this cycle
//   out_dec    out  OUT_W-bit decoded vector (inactive level when idle)
//   out_err    out  output came from a code >= OUT_W
//   clr_err    in   synchronous clear of err_cnt
//   err_cnt    out  saturating count of accepted out-of-range codes
module onehot_decoder_pipe #(
    parameter int SEL_W   = 4,
    parameter int OUT_W   = 16,
    parameter int MODE    = 0,
    parameter int ACT_LOW = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_dec,
    output logic             out_err,
    input  logic             clr_err,
    output logic [7:0]       err_cnt
);

    localparam int unsigned      OUT_WU = OUT_W;
    localparam logic [OUT_W-1:0] INACT  = (ACT_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        STALL = 2'd2
    } state_t;

    // Returns {err, vector}; out-of-range codes decode to the inactive level.
    function automatic logic [OUT_W:0] decode(input logic [SEL_W-1:0] sel);
        int unsigned      s;
        logic [OUT_W-1:0] v;
        logic             err;
        s   = 32'(sel);
        err = (s >= OUT_WU);
        v   = '0;
        for (int unsigned i = 0; i < OUT_WU; i++) begin
            if (MODE == 0) v[i] = (i == s);
            else           v[i] = (i <= s);
        end
        if (err)          v = '0;
        if (ACT_LOW != 0) v = ~v;
        return {err, v};
    endfunction

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [OUT_W-1:0] o_dec_q;
    logic             o_err_q;
    logic [OUT_W-1:0] s_dec_q;
    logic             s_err_q;
    logic [7:0]       err_cnt_q;
    logic [7:0]       err_cnt_d;

    logic [OUT_W-1:0] dec_d;
    logic             err_d;
    logic             in_fire;
    logic             out_fire;

    assign {err_d, dec_d} = decode(in_sel);
    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    // Clear wins over increment, but a same-cycle bad code still counts once.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_err)
            err_cnt_d = (in_fire && err_d) ? 8'd1 : 8'd0;
        else if (in_fire && err_d && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;
    end

    // The output register is reloaded with the inactive level whenever it
    // empties, so out_dec/out_err drive directly from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            o_dec_q     <= INACT;
            o_err_q     <= 1'b0;
            s_dec_q     <= INACT;
            s_err_q     <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
            case (state_q)
                IDLE: begin
                    if (in_fire) begin
                        o_dec_q     <= dec_d;
                        o_err_q     <= err_d;
                        out_valid_q <= 1'b1;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (out_fire && in_fire) begin
                        o_dec_q <= dec_d;
                        o_err_q <= err_d;
                    end else if (out_fire) begin
                        o_dec_q     <= INACT;
                        o_err_q     <= 1'b0;
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (in_fire) begin
                        s_dec_q    <= dec_d;
                        s_err_q    <= err_d;
                        in_ready_q <= 1'b0;
                        state_q    <= STALL;
                    end
                end
                STALL: begin
                    if (out_fire) begin
                        o_dec_q    <= s_dec_q;
                        o_err_q    <= s_err_q;
                        in_ready_q <= 1'b1;
                        state_q    <= BUSY;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    o_dec_q     <= INACT;
                    o_err_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_dec   = o_dec_q;
    assign out_err   = o_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Scoreboard bench for onehot_decoder_pipe. Three instances:
//   u0: defaults (16 outputs, one-hot, active-high)
//   u1: OUT_W = 9 (codes 9..15 out of range)
//   u2: MODE = 1 thermometer, ACT_LOW = 1
module tb_onehot_decoder_pipe;

    typedef struct {
        logic [15:0] d;
        logic        e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] vld;
    logic [2:0] rdy;
    logic [2:0] oval;
    logic [2:0] ordy;
    logic [2:0] oerr;
    logic [2:0] clr;
    logic [3:0] sel [3];
    logic [7:0] cnt [3];
    logic [15:0] dec0;
    logic [8:0]  dec1;
    logic [15:0] dec2;

    exp_t sb [3][$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    onehot_decoder_pipe u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]), .in_sel(sel[0]),
        .out_valid(oval[0]), .out_ready(ordy[0]), .out_dec(dec0), .out_err(oerr[0]),
        .clr_err(clr[0]), .err_cnt(cnt[0]));

    onehot_decoder_pipe #(.OUT_W(9)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]), .in_sel(sel[1]),
        .out_valid(oval[1]), .out_ready(ordy[1]), .out_dec(dec1), .out_err(oerr[1]),
        .clr_err(clr[1]), .err_cnt(cnt[1]));

    onehot_decoder_pipe #(.MODE(1), .ACT_LOW(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(rdy[2]), .in_sel(sel[2]),
        .out_valid(oval[2]), .out_ready(ordy[2]), .out_dec(dec2), .out_err(oerr[2]),
        .clr_err(clr[2]), .err_cnt(cnt[2]));

    function automatic logic [15:0] getdec(input int i);
        case (i)
            0:       return dec0;
            1:       return {7'h00, dec1};
            default: return dec2;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Offer a code to instance i; push the expected response once accepted.
    task automatic send(input int i, input logic [3:0] s, input logic [15:0] d,
                        input logic e, output int waits);
        logic acc;
        exp_t x;
        waits  = 0;
        acc    = 1'b0;
        vld[i] = 1'b1;
        sel[i] = s;
        while (!acc && waits < 50) begin
            @(negedge clk);
            acc = rdy[i];
            @(posedge clk);
            #1;
            waits++;
        end
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout dut%0d sel=%0d: in_ready stayed 0, required 1", i, s);
        end else begin
            x.d = d;
            x.e = e;
            sb[i].push_back(x);
        end
    endtask

    task automatic monitor();
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < 3; i++) begin
                    if (oval[i] && ordy[i]) begin
                        n_cmp++;
                        if (sb[i].size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_out dut%0d: got dec=%h err=%b, required no output",
                                     i, getdec(i), oerr[i]);
                        end else begin
                            x = sb[i].pop_front();
                            if (getdec(i) !== x.d || oerr[i] !== x.e) begin
                                n_fail++;
                                $display("FAIL out_data dut%0d: got dec=%h err=%b, required dec=%h err=%b",
                                         i, getdec(i), oerr[i], x.d, x.e);
                            end
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int maxw;
        rst_n = 1'b0;
        vld   = 3'b000;
        ordy  = 3'b111;
        clr   = 3'b000;
        for (int i = 0; i < 3; i++) sel[i] = 4'd0;
        fork
            monitor();
        join_none

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  {15'h0, rdy[0]},  16'h0001);
        chk("rst_out_valid", {15'h0, oval[0]}, 16'h0000);
        chk("rst_out_dec",   dec0,             16'h0000);
        chk("rst_out_err",   {15'h0, oerr[0]}, 16'h0000);
        chk("rst_err_cnt",   {8'h0, cnt[0]},   16'h0000);
        chk("rst_dec_actlow", dec2,            16'hFFFF);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Stream 0..15 back to back on u0
        maxw = 0;
        for (int k = 0; k < 16; k++) begin
            send(0, 4'(k), 16'h0001 << k, 1'b0, w);
            if (w > maxw) maxw = w;
            if (k == 0) begin
                chk("latency_valid", {15'h0, oval[0]}, 16'h0001);
                chk("latency_dec",   dec0,             16'h0001);
            end
        end
        vld[0] = 1'b0;
        chk("stream_accept_cycles", 16'(maxw), 16'h0001);
        repeat (3) @(posedge clk);
        #1;
        chk("stream_err_cnt", {8'h0, cnt[0]}, 16'h0000);

        // Range edge on u1 (OUT_W = 9)
        send(1, 4'd8,  16'h0100, 1'b0, w);
        send(1, 4'd9,  16'h0000, 1'b1, w);
        send(1, 4'd15, 16'h0000, 1'b1, w);
        vld[1] = 1'b0;
        @(posedge clk);
        #1;
        chk("range_err_cnt", {8'h0, cnt[1]}, 16'h0002);

        // Back-pressure on u0
        ordy[0] = 1'b0;
        send(0, 4'd3, 16'h0008, 1'b0, w);
        send(0, 4'd5, 16'h0020, 1'b0, w);
        sel[0] = 4'd7;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", {15'h0, rdy[0]},  16'h0000);
            chk("bp_hold_dec", dec0,             16'h0008);
            chk("bp_valid",    {15'h0, oval[0]}, 16'h0001);
        end
        @(posedge clk);
        #1;
        ordy[0] = 1'b1;
        send(0, 4'd7, 16'h0080, 1'b0, w);
        vld[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drained_dec", dec0, 16'h0000);

        // Thermometer, active-low on u2
        chk("therm_idle_dec", dec2, 16'hFFFF);
        send(2, 4'd2,  16'hFFF8, 1'b0, w);
        send(2, 4'd15, 16'h0000, 1'b0, w);
        vld[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("therm_back_idle", dec2, 16'hFFFF);

        // Saturation and clear on u1
        for (int k = 0; k < 300; k++)
            send(1, 4'(9 + (k % 7)), 16'h0000, 1'b1, w);
        vld[1] = 1'b0;
        @(posedge clk);
        #1;
        chk("sat_err_cnt", {8'h0, cnt[1]}, 16'h00FF);
        clr[1] = 1'b1;
        send(1, 4'd12, 16'h0000, 1'b1, w);
        clr[1] = 1'b0;
        vld[1] = 1'b0;
        chk("clr_with_err", {8'h0, cnt[1]}, 16'h0001);
        clr[1] = 1'b1;
        @(posedge clk);
        #1;
        clr[1] = 1'b0;
        chk("clr_alone", {8'h0, cnt[1]}, 16'h0000);
        send(1, 4'd10, 16'h0000, 1'b1, w);
        vld[1] = 1'b0;
        chk("cnt_before_reset", {8'h0, cnt[1]}, 16'h0001);

        // Reset while u0 is in STALL
        ordy[0] = 1'b0;
        send(0, 4'd4, 16'h0010, 1'b0, w);
        send(0, 4'd6, 16'h0040, 1'b0, w);
        vld[0] = 1'b0;
        @(negedge clk);
        chk("stall_in_ready", {15'h0, rdy[0]}, 16'h0000);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) sb[i].delete();
        #1;
        chk("arst_in_ready",  {15'h0, rdy[0]},  16'h0001);
        chk("arst_out_valid", {15'h0, oval[0]}, 16'h0000);
        chk("arst_out_dec",   dec0,             16'h0000);
        chk("arst_out_err",   {15'h0, oerr[0]}, 16'h0000);
        chk("arst_err_cnt",   {8'h0, cnt[1]},   16'h0000);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        send(0, 4'd1, 16'h0002, 1'b0, w);
        vld[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++)
            chk($sformatf("sb_empty_dut%0d", i), 16'(sb[i].size()), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
